// File: rtl/capture_write_pkg.sv
// capture_write_pkg: shared defaults and state encoding for the capture_write
// logic-analyser write path.
//   DEF_DATA_WIDTH  - default probe sample width
//   DEF_ADDR_WIDTH  - default capture buffer address width
//   DEF_MEMORY_SIZE - default capture buffer depth (2**DEF_ADDR_WIDTH)
//   state_t         - capture state machine encoding
package capture_write_pkg;

   localparam int unsigned DEF_DATA_WIDTH  = 8;
   localparam int unsigned DEF_ADDR_WIDTH  = 4;
   localparam int unsigned DEF_MEMORY_SIZE = 1 << DEF_ADDR_WIDTH;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FILL      = 3'd1,
      WAIT_TRIG = 3'd2,
      POST      = 3'd3,
      DONE      = 3'd4
   } state_t;

endpackage

// File: rtl/capture_write_trig_match.sv
// capture_write_trig_match: masked trigger compare for the capture path.
//   clk, reset : clock, async active-low reset
//   sample     : probe sample of the current cycle
//   mask/value : trigger mask and pattern (mask bit 0 = don't care)
//   en         : sample belongs to the trigger search window
//   hit_c      : combinational match of the current sample
//   hit        : registered, enabled match; lines up with the buffer write
//                of the same sample one cycle later
module capture_write_trig_match #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] sample,
   input  logic [DATA_WIDTH-1:0] mask,
   input  logic [DATA_WIDTH-1:0] value,
   input  logic                  en,
   output logic                  hit_c,
   output logic                  hit
);

   assign hit_c = ((sample ^ value) & mask) == '0;

   // Delayed hit tags the write strobe carrying the trigger sample
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) hit <= 1'b0;
      else        hit <= en & hit_c;
   end

endmodule

// File: rtl/capture_write.sv
// capture_write: pre/post-trigger capture controller writing probe samples
// into a circular buffer.
//   clk, reset            : clock, async active-low reset
//   arm                   : one-cycle pulse starting a capture (IDLE/DONE only)
//   sample_in             : probe sample, one per clock
//   trig_mask, trig_value : masked trigger pattern
//   post_count            : samples kept after the trigger sample
//   mem_we/waddr/wdata    : registered buffer write port (latency 1)
//   waddr                 : oldest-sample address once done
//   trig_addr             : buffer address of the trigger sample
//   done                  : capture complete, buffer stable
module capture_write
   import capture_write_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  arm,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic [DATA_WIDTH-1:0] trig_mask,
   input  logic [DATA_WIDTH-1:0] trig_value,
   input  logic [ADDR_WIDTH-1:0] post_count,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic                  done
);

   localparam int unsigned MEMORY_SIZE = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_WIDTH   = ADDR_WIDTH + 1;

   state_t                 state, state_next;
   logic [ADDR_WIDTH-1:0]  wptr;
   logic [ADDR_WIDTH-1:0]  post_q;
   logic [CNT_WIDTH-1:0]   cnt;
   logic [CNT_WIDTH-1:0]   pre_depth_c;
   logic                   hit_c;
   logic                   hit;
   logic                   start_c;
   logic                   wr_c;
   logic                   cnt_clr_c;

   // Samples written before the trigger search opens
   assign pre_depth_c = CNT_WIDTH'(MEMORY_SIZE - 1) - {1'b0, post_q};

   capture_write_trig_match #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_trig_match (
      .clk    (clk),
      .reset  (reset),
      .sample (sample_in),
      .mask   (trig_mask),
      .value  (trig_value),
      .en     (state == WAIT_TRIG),
      .hit_c  (hit_c),
      .hit    (hit)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next state and per-cycle controls
   always_comb begin
      state_next = state;
      start_c    = 1'b0;
      wr_c       = 1'b0;
      cnt_clr_c  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (arm) begin
               start_c    = 1'b1;
               // All-ones post_count leaves no pre-trigger room
               state_next = (post_count == '1) ? WAIT_TRIG : FILL;
            end
         end
         FILL: begin
            wr_c = 1'b1;
            if (cnt + CNT_WIDTH'(1) == pre_depth_c) state_next = WAIT_TRIG;
         end
         WAIT_TRIG: begin
            wr_c = 1'b1;
            if (hit_c) begin
               cnt_clr_c  = 1'b1;
               state_next = (post_q == '0) ? DONE : POST;
            end
         end
         POST: begin
            wr_c = 1'b1;
            if (cnt + CNT_WIDTH'(1) == {1'b0, post_q}) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Pointers, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr      <= '0;
         post_q    <= '0;
         cnt       <= '0;
         mem_we    <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= '0;
         waddr     <= '0;
         trig_addr <= '0;
         done      <= 1'b0;
      end else begin
         if (start_c) begin
            post_q <= post_count;
            wptr   <= '0;
         end else if (wr_c) begin
            wptr <= wptr + ADDR_WIDTH'(1);
         end

         if (start_c || cnt_clr_c)             cnt <= '0;
         else if (state == FILL || state == POST) cnt <= cnt + CNT_WIDTH'(1);

         mem_we <= wr_c;
         if (wr_c) begin
            mem_waddr <= wptr;
            mem_wdata <= sample_in;
         end

         // Trigger sample address is taken off the write port it travels on
         if (hit) trig_addr <= mem_waddr;

         // wptr is frozen in DONE, so it already points past the last write
         done <= (state == DONE) && !arm;
         if (state == DONE && !arm) waddr <= wptr;
      end
   end

endmodule

// File: tb/tb_capture_write.sv
// tb_capture_write: directed bench for capture_write (ADDR_WIDTH=4,
// DATA_WIDTH=8). Drives a counting probe sample, keeps a model of the
// capture buffer fed by the write port, and compares against hand-computed
// trigger/oldest addresses, write counts and buffer contents.
module tb_capture_write;
   import capture_write_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       arm;
   logic [7:0] sample_in;
   logic [7:0] trig_mask;
   logic [7:0] trig_value;
   logic [3:0] post_count;
   logic       mem_we;
   logic [3:0] mem_waddr;
   logic [7:0] mem_wdata;
   logic [3:0] waddr;
   logic [3:0] trig_addr;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;

   // Buffer model and write-port activity
   logic [7:0] mem_m [16];
   int         cyc       = 0;
   int         n_wr      = 0;
   int         last_we   = 0;
   int         done_rise = 0;
   logic       done_prev = 1'b0;

   capture_write dut (
      .clk        (clk),
      .reset      (reset),
      .arm        (arm),
      .sample_in  (sample_in),
      .trig_mask  (trig_mask),
      .trig_value (trig_value),
      .post_count (post_count),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .waddr      (waddr),
      .trig_addr  (trig_addr),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (mem_we) begin
         mem_m[mem_waddr] = mem_wdata;
         n_wr    = n_wr + 1;
         last_we = cyc;
      end
      if (done && !done_prev) done_rise = cyc;
      done_prev = done;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One capture: arm with arm_s on the sample bus, then count samples
   // 0,1,2,... from the first FILL/WAIT_TRIG cycle.
   task automatic capture(input string name, input logic [3:0] pc,
                          input logic [7:0] m, input logic [7:0] v,
                          input logic [7:0] arm_s, input int arm_at,
                          input int rst_at, input int exp_wr,
                          input logic [3:0] exp_ta, input logic [3:0] exp_wa,
                          input logic [7:0] exp_trig,
                          input logic [3:0] ca, input logic [7:0] cd);
      int   base;
      int   idx;
      logic ok;
      @(negedge clk);
      post_count = pc;
      trig_mask  = m;
      trig_value = v;
      sample_in  = arm_s;
      arm        = 1'b1;
      base       = n_wr;
      @(negedge clk);
      arm       = 1'b0;
      idx       = 0;
      sample_in = 8'(idx);
      check({name, "_done_drop"}, 32'(done), 32'd0);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
         idx       = idx + 1;
         sample_in = 8'(idx);
         arm       = (idx == arm_at);
         if (idx == rst_at) begin
            check({name, "_pre_rst_we"}, 32'(mem_we), 32'd1);
            arm   = 1'b0;
            reset = 1'b0;
            #1;
            check({name, "_rst_we"},    32'(mem_we),    32'd0);
            check({name, "_rst_maddr"}, 32'(mem_waddr), 32'd0);
            check({name, "_rst_mdata"}, 32'(mem_wdata), 32'd0);
            check({name, "_rst_waddr"}, 32'(waddr),     32'd0);
            check({name, "_rst_taddr"}, 32'(trig_addr), 32'd0);
            check({name, "_rst_done"},  32'(done),      32'd0);
            check({name, "_rst_state"}, 32'(dut.state), 32'(IDLE));
            @(negedge clk);
            reset = 1'b1;
            return;
         end
      end
      arm = 1'b0;
      check({name, "_finished"}, 32'(ok), 32'd1);
      if (ok) begin
         check({name, "_writes"},    32'(n_wr - base),          32'(exp_wr));
         check({name, "_done_lat"},  32'(done_rise - last_we),  32'd1);
         check({name, "_we_done"},   32'(mem_we),               32'd0);
         check({name, "_taddr"},     32'(trig_addr),            32'(exp_ta));
         check({name, "_waddr"},     32'(waddr),                32'(exp_wa));
         check({name, "_trig_mem"},  32'(mem_m[exp_ta]),        32'(exp_trig));
         check({name, "_mem"},       32'(mem_m[ca]),            32'(cd));
      end
   endtask

   initial begin
      reset      = 1'b0;
      arm        = 1'b0;
      sample_in  = '0;
      trig_mask  = '0;
      trig_value = '0;
      post_count = '0;
      for (int a = 0; a < 16; a++) mem_m[a] = '0;
      #2;
      check("reset_we",    32'(mem_we),    32'd0);
      check("reset_maddr", 32'(mem_waddr), 32'd0);
      check("reset_mdata", 32'(mem_wdata), 32'd0);
      check("reset_waddr", 32'(waddr),     32'd0);
      check("reset_taddr", 32'(trig_addr), 32'd0);
      check("reset_done",  32'(done),      32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_we",   32'(mem_we), 32'd0);
      check("idle_done", 32'(done),   32'd0);

      // post 4: 11 fill, trigger 0x20 at addr 0, waddr 5 holds 0x15
      capture("post4", 4'd4, 8'hFF, 8'h20, 8'h20, -1, -1,
              37, 4'h0, 4'h5, 8'h20, 4'h5, 8'h15);
      // post 0: 0x03 inside fill ignored, 0x13 captures at addr 3
      capture("post0", 4'd0, 8'h0F, 8'h03, 8'h03, -1, -1,
              20, 4'h3, 4'h4, 8'h13, 4'h4, 8'h04);
      // post 15: no pre-trigger samples, trigger at addr 0
      capture("post15", 4'd15, 8'hFF, 8'h00, 8'h00, -1, -1,
              16, 4'h0, 4'h0, 8'h00, 4'hF, 8'h0F);
      // mask 0: trigger on first search cycle, arm in POST ignored
      capture("mask0", 4'd4, 8'h00, 8'h00, 8'h55, 13, -1,
              16, 4'hB, 4'h0, 8'h0B, 4'hF, 8'h0F);
      // re-arm from DONE repeats identically
      capture("mask0_rep", 4'd4, 8'h00, 8'h00, 8'h55, 13, -1,
              16, 4'hB, 4'h0, 8'h0B, 4'hF, 8'h0F);
      // reset in the middle of POST abandons the capture
      capture("rst_post", 4'd4, 8'hFF, 8'h20, 8'h20, -1, 34,
              0, 4'h0, 4'h0, 8'h00, 4'h0, 8'h00);
      repeat (2) @(negedge clk);
      check("rst_idle_we", 32'(mem_we), 32'd0);
      // clean capture after the abort
      capture("post4_again", 4'd4, 8'hFF, 8'h20, 8'h20, -1, -1,
              37, 4'h0, 4'h5, 8'h20, 4'h5, 8'h15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
